// File: rtl/noc_pkg.sv
// Shared flit encodings, header field positions and receiver FSM states.
`timescale 1ns/1ps
package noc_pkg;

  localparam logic [1:0] FT_HEAD = 2'b11;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b01;
  localparam logic [1:0] FT_INV  = 2'b00;

  // Header field bit positions within a 40-bit flit
  localparam int unsigned SRC_X_HI    = 37;
  localparam int unsigned SRC_X_LO    = 34;
  localparam int unsigned SRC_Y_HI    = 33;
  localparam int unsigned SRC_Y_LO    = 30;
  localparam int unsigned DST_X_HI    = 29;
  localparam int unsigned DST_X_LO    = 26;
  localparam int unsigned DST_Y_HI    = 25;
  localparam int unsigned DST_Y_LO    = 22;
  localparam int unsigned HDR_DATA_HI = 21;
  localparam int unsigned HDR_DATA_LO = 0;

  typedef enum logic [1:0] {
    StIdle,
    StBody,
    StDrop
  } state_e;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented combinationally, zero when empty.
`timescale 1ns/1ps
module flit_fifo #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/pe_flit_receiver.sv
// PE-side ejection interface: frames header/body/tail flits, checks routing and length,
// and queues packet data for the processing element.
`timescale 1ns/1ps
module pe_flit_receiver
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W  = 40,
  parameter int unsigned DEPTH   = 8,
  parameter logic [3:0]  LOCAL_X = 4'h2,
  parameter logic [3:0]  LOCAL_Y = 4'h1,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [FLIT_W-1:0] i_flit_in,
  input  logic              i_req_in,
  output logic              o_grant_out,
  output logic [37:0]       o_pe_data,
  output logic              o_pe_last,
  output logic              o_pe_valid,
  input  logic              i_pe_rd,
  output logic              o_hdr_valid,
  output logic [3:0]        o_hdr_src_x,
  output logic [3:0]        o_hdr_src_y,
  output logic [21:0]       o_hdr_data,
  output logic              o_pkt_done,
  output logic [4:0]        o_pkt_len,
  output logic              o_err_misroute,
  output logic              o_err_orphan,
  output logic              o_err_trunc,
  output logic              o_err_len,
  output logic              o_err_type,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e      r_state, w_state_next;
  logic [4:0]  r_len, w_len_next;
  logic        r_grant;
  logic        r_hdr_valid, w_hdr_valid;
  logic [3:0]  r_src_x, w_src_x;
  logic [3:0]  r_src_y, w_src_y;
  logic [21:0] r_hdr_data, w_hdr_data;
  logic        r_pkt_done, w_pkt_done;
  logic [4:0]  r_pkt_len, w_pkt_len;
  logic        r_err_misroute, w_err_misroute;
  logic        r_err_orphan, w_err_orphan;
  logic        r_err_trunc, w_err_trunc;
  logic        r_err_len, w_err_len;
  logic        r_err_type, w_err_type;

  logic             w_accept;
  logic [1:0]       w_type;
  logic             w_is_tail;
  logic             w_dst_ok;
  logic             w_push;
  logic             w_pop_ok;
  logic [38:0]      w_head;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;

  assign w_accept  = i_req_in && r_grant;
  assign w_type    = i_flit_in[FLIT_W-1 -: 2];
  assign w_is_tail = (w_type == FT_TAIL);
  assign w_dst_ok  = (i_flit_in[DST_X_HI:DST_X_LO] == LOCAL_X) &&
                     (i_flit_in[DST_Y_HI:DST_Y_LO] == LOCAL_Y);

  always_comb begin
    w_state_next   = r_state;
    w_len_next     = r_len;
    w_src_x        = r_src_x;
    w_src_y        = r_src_y;
    w_hdr_data     = r_hdr_data;
    w_pkt_len      = r_pkt_len;
    w_hdr_valid    = 1'b0;
    w_pkt_done     = 1'b0;
    w_err_misroute = 1'b0;
    w_err_orphan   = 1'b0;
    w_err_trunc    = 1'b0;
    w_err_len      = 1'b0;
    w_err_type     = 1'b0;
    w_push         = 1'b0;

    if (w_accept) begin
      unique case (w_type)
        FT_INV: w_err_type = 1'b1;
        FT_HEAD: begin
          // A header always opens a new packet; an unfinished one is flagged only from BODY
          w_err_trunc = (r_state == StBody);
          w_hdr_valid = 1'b1;
          w_src_x     = i_flit_in[SRC_X_HI:SRC_X_LO];
          w_src_y     = i_flit_in[SRC_Y_HI:SRC_Y_LO];
          w_hdr_data  = i_flit_in[HDR_DATA_HI:HDR_DATA_LO];
          w_len_next  = '0;
          if (w_dst_ok) begin
            w_state_next = StBody;
          end else begin
            w_err_misroute = 1'b1;
            w_state_next   = StDrop;
          end
        end
        FT_BODY, FT_TAIL: begin
          unique case (r_state)
            StIdle: w_err_orphan = 1'b1;
            StBody: begin
              if (r_len == 5'(MAX_LEN)) begin
                w_err_len    = 1'b1;
                w_state_next = w_is_tail ? StIdle : StDrop;
              end else begin
                w_push     = 1'b1;
                w_len_next = r_len + 5'd1;
                if (w_is_tail) begin
                  w_pkt_done   = 1'b1;
                  w_pkt_len    = r_len + 5'd1;
                  w_state_next = StIdle;
                end
              end
            end
            StDrop: begin
              if (w_is_tail) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
          endcase
        end
      endcase
    end
  end

  assign w_pop_ok     = i_pe_rd && (w_count != '0);
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_len          <= '0;
      r_grant        <= 1'b1;
      r_hdr_valid    <= 1'b0;
      r_src_x        <= '0;
      r_src_y        <= '0;
      r_hdr_data     <= '0;
      r_pkt_done     <= 1'b0;
      r_pkt_len      <= '0;
      r_err_misroute <= 1'b0;
      r_err_orphan   <= 1'b0;
      r_err_trunc    <= 1'b0;
      r_err_len      <= 1'b0;
      r_err_type     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_len          <= w_len_next;
      r_grant        <= (w_count_next < CNT_W'(DEPTH));
      r_hdr_valid    <= w_hdr_valid;
      r_src_x        <= w_src_x;
      r_src_y        <= w_src_y;
      r_hdr_data     <= w_hdr_data;
      r_pkt_done     <= w_pkt_done;
      r_pkt_len      <= w_pkt_len;
      r_err_misroute <= w_err_misroute;
      r_err_orphan   <= w_err_orphan;
      r_err_trunc    <= w_err_trunc;
      r_err_len      <= w_err_len;
      r_err_type     <= w_err_type;
    end
  end

  flit_fifo #(
    .WIDTH (39),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data ({w_is_tail, i_flit_in[37:0]}),
    .i_pop       (i_pe_rd),
    .o_data      (w_head),
    .o_valid     (o_pe_valid),
    .o_count     (w_count)
  );

  assign o_grant_out    = r_grant;
  assign o_pe_data      = w_head[37:0];
  assign o_pe_last      = w_head[38];
  assign o_hdr_valid    = r_hdr_valid;
  assign o_hdr_src_x    = r_src_x;
  assign o_hdr_src_y    = r_src_y;
  assign o_hdr_data     = r_hdr_data;
  assign o_pkt_done     = r_pkt_done;
  assign o_pkt_len      = r_pkt_len;
  assign o_err_misroute = r_err_misroute;
  assign o_err_orphan   = r_err_orphan;
  assign o_err_trunc    = r_err_trunc;
  assign o_err_len      = r_err_len;
  assign o_err_type     = r_err_type;
  assign o_busy         = (r_state != StIdle);

endmodule
